// File: rtl/ntt_sched_pkg.sv
// ntt_sched_pkg: shared word width and FSM state encoding for the NTT butterfly scheduler
//   WORD    : width of the cycle counter
//   state_t : IDLE=0, ISSUE=1, DRAIN=2, DONE=3
package ntt_sched_pkg;
  localparam int WORD = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/ntt_sched_wb_pipe.sv
// ntt_wb_pipe: BF_LAT-deep write-back delay line of {valid, a, b} with async clear
//   i_valid/i_a/i_b : accepted butterfly pair entering the line
//   o_valid/o_a/o_b : pair leaving the line BF_LAT cycles later
//   o_empty_next    : no valid entry will remain after the coming edge
module ntt_wb_pipe #(
  parameter int LOGN   = 3,
  parameter int BF_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [LOGN-1:0] i_a,
  input  logic [LOGN-1:0] i_b,
  output logic            o_valid,
  output logic [LOGN-1:0] o_a,
  output logic [LOGN-1:0] o_b,
  output logic            o_empty_next
);
  logic [BF_LAT-1:0] r_v;
  logic [LOGN-1:0]   r_a [BF_LAT];
  logic [LOGN-1:0]   r_b [BF_LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < BF_LAT; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else begin
      r_v[0] <= i_valid;
      r_a[0] <= i_a;
      r_b[0] <= i_b;
      for (int k = 1; k < BF_LAT; k++) begin
        r_v[k] <= r_v[k-1];
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
    end
  end
  // the output stage drains this edge, so only the input and the earlier stages matter
  always_comb begin
    o_empty_next = !i_valid;
    for (int k = 0; k < BF_LAT-1; k++) o_empty_next = o_empty_next & !r_v[k];
  end
  assign o_valid = r_v[BF_LAT-1];
  assign o_a     = r_a[BF_LAT-1];
  assign o_b     = r_b[BF_LAT-1];
endmodule

// File: rtl/ntt_sched.sv
// ntt_sched: radix-2 Cooley-Tukey NTT butterfly scheduler with stage drain
//   i_start                 : begin a transform (sampled in IDLE)
//   o_busy/o_done/o_stage   : status, one-cycle done pulse, current stage
//   o_rd_*/i_rd_ready       : butterfly read pair + twiddle exponent, valid/ready
//   o_wr_*                  : write-back pair, BF_LAT cycles after acceptance
//   o_cycle_count           : saturating count of ISSUE and DRAIN cycles
module ntt_sched
  import ntt_sched_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOGN   = 3,
  parameter int BF_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  output logic [LOGN-1:0] o_stage,
  output logic            o_rd_valid,
  input  logic            i_rd_ready,
  output logic [LOGN-1:0] o_rd_a,
  output logic [LOGN-1:0] o_rd_b,
  output logic [LOGN-2:0] o_tw_idx,
  output logic            o_wr_valid,
  output logic [LOGN-1:0] o_wr_a,
  output logic [LOGN-1:0] o_wr_b,
  output logic [WORD-1:0] o_cycle_count
);
  state_t          r_state, w_state_nx;
  logic [LOGN-1:0] r_s, w_s_nx;
  logic [LOGN-2:0] r_j, w_j_nx;
  logic [WORD-1:0] r_cnt, w_cnt_nx;
  logic            w_issue, w_hs, w_last_j, w_last_s, w_empty_next;
  logic [LOGN-1:0] w_half, w_pos, w_grp, w_a;
  logic [LOGN-2:0] w_tw;
  assign w_issue  = r_state == ISSUE;
  assign w_hs     = w_issue && i_rd_ready;
  assign w_last_j = r_j == (LOGN-1)'(N/2-1);
  assign w_last_s = r_s == LOGN'(LOGN-1);
  // pair j of stage s: group base is grp*2*half, offset pos is below half so OR acts as add
  assign w_half = LOGN'(1) << r_s;
  assign w_pos  = {1'b0, r_j} & (w_half - 1'b1);
  assign w_grp  = {1'b0, r_j} >> r_s;
  assign w_a    = (w_grp << (r_s + 1'b1)) | w_pos;
  assign w_tw   = (LOGN-1)'(w_pos << (LOGN'(LOGN-1) - r_s));
  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_j_nx     = r_j;
    w_cnt_nx   = (w_issue || r_state == DRAIN) && r_cnt != '1 ? r_cnt + 1'b1 : r_cnt;
    case (r_state)
      IDLE: if (i_start) begin
        w_state_nx = ISSUE;
        w_s_nx     = '0;
        w_j_nx     = '0;
        w_cnt_nx   = '0;
      end
      ISSUE: if (w_hs) begin
        w_j_nx     = r_j + 1'b1;
        w_state_nx = w_last_j ? DRAIN : ISSUE;
      end
      DRAIN: if (w_empty_next) begin
        w_state_nx = w_last_s ? DONE : ISSUE;
        w_s_nx     = w_last_s ? r_s : r_s + 1'b1;
        w_j_nx     = '0;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_j     <= w_j_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  ntt_wb_pipe #(.LOGN(LOGN), .BF_LAT(BF_LAT)) u_wb (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (w_hs),
    .i_a          (w_a),
    .i_b          (w_a + w_half),
    .o_valid      (o_wr_valid),
    .o_a          (o_wr_a),
    .o_b          (o_wr_b),
    .o_empty_next (w_empty_next)
  );
  assign o_busy        = r_state != IDLE;
  assign o_done        = r_state == DONE;
  assign o_stage       = r_s;
  assign o_rd_valid    = w_issue;
  assign o_rd_a        = w_issue ? w_a : '0;
  assign o_rd_b        = w_issue ? w_a + w_half : '0;
  assign o_tw_idx      = w_issue ? w_tw : '0;
  assign o_cycle_count = r_cnt;
endmodule

// File: tb/tb_ntt_sched.sv
// tb_ntt_sched: checks ntt_sched (N=8/LAT=2 and N=16/LAT=1) against a queue-based schedule model
module tb_ntt_sched;
  logic clk = 1'b0;
  logic rst;
  logic st [2];
  logic rdy [2];
  always #5 clk = ~clk;

  logic       b0, d0, v0, wv0;
  logic [2:0] s0, a0, bb0, wa0, wb0;
  logic [1:0] t0;
  logic [15:0] c0;
  logic       b1, d1, v1, wv1;
  logic [3:0] s1, a1, bb1, wa1, wb1;
  logic [2:0] t1;
  logic [15:0] c1;

  ntt_sched #(.N(8), .LOGN(3), .BF_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .i_start(st[0]), .o_busy(b0), .o_done(d0), .o_stage(s0),
    .o_rd_valid(v0), .i_rd_ready(rdy[0]), .o_rd_a(a0), .o_rd_b(bb0), .o_tw_idx(t0),
    .o_wr_valid(wv0), .o_wr_a(wa0), .o_wr_b(wb0), .o_cycle_count(c0));
  ntt_sched #(.N(16), .LOGN(4), .BF_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(st[1]), .o_busy(b1), .o_done(d1), .o_stage(s1),
    .o_rd_valid(v1), .i_rd_ready(rdy[1]), .o_rd_a(a1), .o_rd_b(bb1), .o_tw_idx(t1),
    .o_wr_valid(wv1), .o_wr_a(wa1), .o_wr_b(wb1), .o_cycle_count(c1));

  int o_busy[2], o_done[2], o_rv[2], o_wv[2], o_ra[2], o_rb[2], o_tw[2], o_st[2], o_wa[2], o_wb[2], o_cnt[2];
  always_comb begin
    o_busy[0] = int'(b0); o_done[0] = int'(d0); o_rv[0] = int'(v0); o_wv[0] = int'(wv0);
    o_ra[0] = int'(a0); o_rb[0] = int'(bb0); o_tw[0] = int'(t0); o_st[0] = int'(s0);
    o_wa[0] = int'(wa0); o_wb[0] = int'(wb0); o_cnt[0] = int'(c0);
    o_busy[1] = int'(b1); o_done[1] = int'(d1); o_rv[1] = int'(v1); o_wv[1] = int'(wv1);
    o_ra[1] = int'(a1); o_rb[1] = int'(bb1); o_tw[1] = int'(t1); o_st[1] = int'(s1);
    o_wa[1] = int'(wa1); o_wb[1] = int'(wb1); o_cnt[1] = int'(c1);
  end

  int n_p[2] = '{8, 16};
  int lg_p[2] = '{3, 4};
  int lat_p[2] = '{2, 1};
  int L_A[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int L_B[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int L_T[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  int pa[2][32], pb[2][32], pt[2][32], ps[2][32], hd[2], nq[2];
  int wa[2][32], wb[2][32], wd[2][32], ws[2][32], wh[2], wt[2];
  int lga[2][32], lgb[2][32], lgt[2][32], nl[2];
  int act[2], mcnt[2], ndone[2], stl[2], tst[2];
  int cyc, ci, ph, tmo, tmo_seen;
  int checks, errors;

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", nm, ci, cyc, a, e);
    end
  endtask

  always @(negedge clk) begin
    int prevp, erv, edn, ewv, h;
    cyc++;
    if (tmo != tmo_seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: done count %0d/%0d not reached", ndone[0], ndone[1]);
      tmo_seen = tmo;
    end
    for (int i = 0; i < 2; i++) begin
      ci = i;
      if (rst) begin
        chk("rst_flags", o_busy[i] + o_done[i] + o_rv[i] + o_wv[i], 0);
        chk("rst_addr", o_ra[i] + o_rb[i] + o_tw[i] + o_st[i] + o_wa[i] + o_wb[i], 0);
        chk("rst_cnt", o_cnt[i], 0);
        act[i] = 0; hd[i] = 0; nq[i] = 0; wh[i] = 0; wt[i] = 0; mcnt[i] = 0;
      end else begin
        prevp = 0;
        if (hd[i] < nq[i])
          for (int k = wh[i]; k < wt[i]; k++) if (ws[i][k] != ps[i][hd[i]]) prevp = 1;
        erv = int'(act[i] != 0 && hd[i] < nq[i] && prevp == 0);
        edn = int'(act[i] != 0 && hd[i] == nq[i] && wh[i] == wt[i]);
        ewv = int'(wh[i] < wt[i] && wd[i][wh[i]] == cyc);
        chk("busy", o_busy[i], act[i]);
        chk("done", o_done[i], edn);
        chk("rd_valid", o_rv[i], erv);
        chk("wr_valid", o_wv[i], ewv);
        chk("cycle_count", o_cnt[i], mcnt[i]);
        if (ewv != 0) begin
          chk("wr_a", o_wa[i], wa[i][wh[i]]);
          chk("wr_b", o_wb[i], wb[i][wh[i]]);
          wh[i]++;
        end
        if (erv != 0) begin
          chk("rd_a", o_ra[i], pa[i][hd[i]]);
          chk("rd_b", o_rb[i], pb[i][hd[i]]);
          chk("tw_idx", o_tw[i], pt[i][hd[i]]);
          chk("stage", o_st[i], ps[i][hd[i]]);
          if (rdy[i]) begin
            lga[i][nl[i]] = o_ra[i]; lgb[i][nl[i]] = o_rb[i]; lgt[i][nl[i]] = o_tw[i]; nl[i]++;
            wa[i][wt[i]] = pa[i][hd[i]]; wb[i][wt[i]] = pb[i][hd[i]];
            wd[i][wt[i]] = cyc + lat_p[i]; ws[i][wt[i]] = ps[i][hd[i]]; wt[i]++;
            hd[i]++;
          end else stl[i]++;
        end
        if (act[i] != 0 && edn == 0) mcnt[i]++;
        if (edn != 0) begin
          ndone[i]++;
          act[i] = 0;
          if (ph == 1 && i == 0) begin
            chk("pairs_logged", nl[0], 12);
            for (int k = 0; k < 12; k++) begin
              chk("lit_a", lga[0][k], L_A[k]);
              chk("lit_b", lgb[0][k], L_B[k]);
              chk("lit_tw", lgt[0][k], L_T[k]);
            end
            chk("lit_done_lat", cyc - tst[0], 19);
            chk("lit_count", o_cnt[0], 18);
          end
          if (ph == 1 && i == 1) begin
            for (int k = 0; k < 8; k++) chk("lit_tw_s3", lgt[1][24+k], k);
            chk("lit_done_lat16", cyc - tst[1], 37);
            chk("lit_count16", o_cnt[1], 36);
          end
          if (ph == 2 && i == 0) begin
            chk("stall_count", o_cnt[0], 18 + stl[0]);
            chk("stall_lat", cyc - tst[0], 19 + stl[0]);
          end
          if (ph == 4 && i == 0) begin
            chk("rerun_lat", cyc - tst[0], 19);
            chk("rerun_count", o_cnt[0], 18);
          end
        end else if (act[i] == 0 && st[i]) begin
          act[i] = 1; mcnt[i] = 0; hd[i] = 0; nq[i] = 0; wh[i] = 0; wt[i] = 0;
          nl[i] = 0; stl[i] = 0; tst[i] = cyc;
          for (int s = 0; s < lg_p[i]; s++) begin
            h = 1 << s;
            for (int blk = 0; blk < n_p[i]; blk += 2 * h)
              for (int p = 0; p < h; p++) begin
                pa[i][nq[i]] = blk + p;
                pb[i][nq[i]] = blk + p + h;
                pt[i][nq[i]] = p * (n_p[i] / (2 * h));
                ps[i][nq[i]] = s;
                nq[i]++;
              end
          end
        end
      end
    end
  end

  task automatic wait_done(input int i, input int base, input int lim);
    int k = 0;
    while (ndone[i] == base && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (ndone[i] == base) tmo++;
  endtask

  initial begin
    int base0, base1, k;
    rst = 1'b1; st[0] = 1'b0; st[1] = 1'b0; rdy[0] = 1'b1; rdy[1] = 1'b1;
    ph = 0; tmo = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 ph = 1; base0 = ndone[0]; base1 = ndone[1];
    st[0] = 1'b1; st[1] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0; st[1] = 1'b0;
    wait_done(0, base0, 100);
    wait_done(1, base1, 100);
    repeat (3) @(posedge clk);
    #1 ph = 2; base0 = ndone[0];
    st[0] = 1'b1; rdy[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    k = 1;
    while (ndone[0] == base0 && k < 200) begin
      rdy[0] = ((k - 1) % 3 == 0);
      st[0] = (k == 4) || d0;
      @(posedge clk);
      #1 k++;
    end
    st[0] = 1'b0; rdy[0] = 1'b1;
    if (ndone[0] == base0) tmo++;
    repeat (10) @(posedge clk);
    #1 ph = 3;
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    k = 0;
    while (s0 != 3'd1 && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 ph = 4; base0 = ndone[0];
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    wait_done(0, base0, 100);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ntt_sched.md
# ntt_sched

Butterfly scheduler for the in-place iterative radix-2 Cooley-Tukey NTT over an N-point coefficient memory. It is started by the top-level `compute` control and walks all log2(N) stages. For each stage it issues the N/2 butterfly read-address pairs with twiddle exponents to the butterfly unit through a valid/ready handshake. It delays each accepted pair by the butterfly latency to generate write-back addresses, and drains the pipeline between stages so that stage s+1 never reads a stage-s result that is still in flight.

## Interface
- `N`, default 8: transform size; power of two, at least 4.
- `LOGN`, default 3: log2(N); also the address width.
- `BF_LAT`, default 2: butterfly latency in cycles; at least 1.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin a transform; sampled only in IDLE.
- `busy`  out  1: state is not IDLE; includes the DONE cycle.
- `done`  out  1: one-cycle pulse in DONE.
- `stage`  out  LOGN: current stage index s.
- `rd_valid`  out  1: a butterfly pair is offered.
- `rd_ready`  in  1: butterfly unit accepts the pair.
- `rd_a`, `rd_b`  out  LOGN each: read addresses of the pair.
- `tw_idx`  out  LOGN-1: twiddle exponent k, with twiddle = w_N^k.
- `wr_valid`  out  1: write back the butterfly result now.
- `wr_a`, `wr_b`  out  LOGN each: write-back addresses.
- `cycle_count`  out  `WORD: number of ISSUE and DRAIN cycles in the last or current transform.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 → ISSUE, with s=0, j=0, `cycle_count`=0.
  - `start` in any other state is ignored.
- ISSUE:
  - `rd_valid`=1.
  - A handshake (`rd_valid` and `rd_ready`) increments j.
  - The handshake with j=N/2-1 → DRAIN.
- DRAIN:
  - `rd_valid`=0.
  - Exits at the edge ending the cycle in which the last in-flight `wr_valid` is high.
  - Exit goes to DONE if s=LOGN-1; otherwise s is incremented, j=0, and the state goes to ISSUE.
- DONE: `done`=1 for one cycle → IDLE.
- Address rules for butterfly j of stage s:
  - half = 1<<s; pos = j & (half-1); grp = j>>s.
  - `rd_a` = grp·2·half + pos; `rd_b` = `rd_a` + half.
  - `tw_idx` = pos << (LOGN-1-s).
  - All arithmetic is unsigned in LOGN bits and never wraps.
- While `rd_valid`=1 and `rd_ready`=0, `rd_a`, `rd_b` and `tw_idx` hold stable.
- Write-back delay line:
  - BF_LAT entries, each holding {valid, a, b}. Every entry advances every cycle; there is no backpressure.
  - A handshake in cycle t produces `wr_valid`=1 with the same a and b in cycle t+BF_LAT.
- `cycle_count` increments once per cycle in ISSUE or DRAIN. It holds in DONE and IDLE, and saturates at all ones.
- Reset values:
  - state=IDLE.
  - s=0, j=0.
  - All delay-line valid bits are 0.
  - `busy`, `done`, `rd_valid` and `wr_valid` are 0.
  - Address outputs and `cycle_count` are 0.
- Reset mid-transform aborts immediately. In-flight writes are discarded and no `done` is generated.

## Timing
- `start` sampled at edge E0 puts the first pair on `rd_*` in the cycle after E0. `rd_*` outputs are registered or decoded from registered s and j, with no combinational path from `rd_ready`.
- With `rd_ready` held at 1:
  - Each stage takes N/2+BF_LAT cycles.
  - `done` arrives LOGN·(N/2+BF_LAT)+1 cycles after E0.
  - Final `cycle_count` = LOGN·(N/2+BF_LAT); this is 18 for the defaults.
- Each `rd_ready`=0 cycle during ISSUE adds exactly one cycle.
- `wr_valid` never overlaps `rd_valid` across a stage boundary. It may overlap within a stage.

## Structure
- Shared header `ntt_defs.vh` holds:
  - `WORD.
  - The state encodings: IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
- Sub-module `ntt_wb_pipe` holds the parameterised BF_LAT-deep delay line of {valid, a, b}. It has an asynchronous clear and an `empty_next` flag, which DRAIN uses to exit.
- Address and twiddle generation stay inline in `ntt_sched`.

## Test plan
- Defaults with `rd_ready`=1, pulse `start` → the required sequence:
  - s=0: pairs (0,1) (2,3) (4,5) (6,7), `tw_idx` 0,0,0,0.
  - s=1: pairs (0,2) (1,3) (4,6) (5,7), `tw_idx` 0,2,0,2.
  - s=2: pairs (0,4) (1,5) (2,6) (3,7), `tw_idx` 0,1,2,3.
  - `done` 19 cycles after E0; `cycle_count`=18.
- Each write-back pair equals its read pair exactly 2 cycles after the handshake. No `rd_valid` occurs while a previous-stage `wr_valid` is still pending.
- `rd_ready` toggles 1,0,0,1,… → addresses stay stable during stalls. `cycle_count` = 18 plus the number of stall cycles.
- `start` pulsed during ISSUE and during DONE → ignored; exactly one `done` pulse.
- Assert `rst` in cycle 5 of stage 1 → all outputs 0 in the same cycle, and no `wr_valid` or `done` follows. A new `start` then runs a clean transform from s=0.
- N=16, BF_LAT=1 → 4 stages of 9 cycles each. Stage 3 `tw_idx` = 0..7; `cycle_count`=36.
